// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bus/PHY-side signal bundle of the queued UART transmitter.
//   master : bus agent (drives BusWr/BusData, observes status and the line)
//   slave  : transmitter (consumes writes, drives status and the line)
// Signals:
//   BusWr     write strobe, one push per cycle high
//   BusData   write data, only the low DATA_BITS bits are used
//   BusFull   FIFO full, writes dropped while high
//   BusEmpty  FIFO empty
//   BusLevel  FIFO occupancy, 0..FIFO_DEPTH
//   BusOvf    one-cycle pulse: a write was dropped because the FIFO was full
//   Busy      high while a frame is on the line
//   PhyOut    serial line, idle high
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if #(
    parameter int FIFO_DEPTH = 16
);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);

    logic             BusWr;
    logic [31:0]      BusData;
    logic             BusFull;
    logic             BusEmpty;
    logic [LVL_W-1:0] BusLevel;
    logic             BusOvf;
    logic             Busy;
    logic             PhyOut;

    modport master (
        output BusWr, BusData,
        input  BusFull, BusEmpty, BusLevel, BusOvf, Busy, PhyOut
    );

    modport slave (
        input  BusWr, BusData,
        output BusFull, BusEmpty, BusLevel, BusOvf, Busy, PhyOut
    );
endinterface

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// UART transmitter with a write FIFO. The bus side pushes bytes with
// single-cycle writes; queued bytes are serialised LSB-first as
// START, DATA_BITS data bits, optional parity, STOP_BITS stop bits.
// Consecutive queued frames go out back-to-back with no idle gap.
// Ports:
//   BusClk   bus clock, all logic on posedge
//   BusRstN  asynchronous active-low reset (async assert, sync release)
//   bus      uart_tx_fifo_if.slave: write strobe/data in; full, empty,
//            level, overflow pulse, busy and serial line out
// -----------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int PRESCALER  = 625,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,   // 0 none, 1 odd, 2 even
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic             BusClk,
    input  logic             BusRstN,
    uart_tx_fifo_if.slave    bus
);
    localparam int PTR_W = $clog2(FIFO_DEPTH);
    localparam int LVL_W = $clog2(FIFO_DEPTH + 1);
    localparam int CNT_W = $clog2(PRESCALER);

    // Out-of-range configurations stop elaboration.
    if (PRESCALER < 2 || PRESCALER > 4095) begin : g_bad_prescaler
        $error("uart_tx_fifo: PRESCALER must be 2..4095");
    end
    if (DATA_BITS < 5 || DATA_BITS > 9) begin : g_bad_data_bits
        $error("uart_tx_fifo: DATA_BITS must be 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
        $error("uart_tx_fifo: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
        $error("uart_tx_fifo: STOP_BITS must be 1 or 2");
    end
    if (FIFO_DEPTH < 2 || (FIFO_DEPTH & (FIFO_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("uart_tx_fifo: FIFO_DEPTH must be a power of 2, >= 2");
    end

    typedef enum logic [2:0] {
        S_IDLE,
        S_START,
        S_DATA,
        S_PAR,
        S_STOP
    } state_t;

    // ------------------------------------------------------------------ FIFO
    logic [DATA_BITS-1:0] mem [FIFO_DEPTH];
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr;
    logic [LVL_W-1:0]     level;
    logic                 ovf;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;
    logic [DATA_BITS-1:0] head;

    assign full  = (level == LVL_W'(FIFO_DEPTH));
    assign empty = (level == '0);
    assign push  = bus.BusWr && !full;
    assign head  = mem[rd_ptr];

    // Bits above DATA_BITS are deliberately ignored.
    logic unused_data;
    assign unused_data = ^bus.BusData;

    // NOTE: the storage array has no reset; its contents are only ever read
    // behind a valid level, so clearing it would buy nothing.
    always_ff @(posedge BusClk) begin
        if (push) begin
            mem[wr_ptr] <= bus.BusData[DATA_BITS-1:0];
        end
    end

    // NOTE: clocked state is always updated with non-blocking assignments so
    // every flop samples the pre-edge value of every other flop.
    always_ff @(posedge BusClk or negedge BusRstN) begin
        if (!BusRstN) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            // Pointers are log2(DEPTH) wide and wrap on their own.
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   level <= level + 1'b1;
                2'b01:   level <= level - 1'b1;
                default: level <= level;
            endcase
            ovf <= bus.BusWr && full;
        end
    end

    // ------------------------------------------------------------ serialiser
    state_t               state;
    state_t               state_next;
    logic [CNT_W-1:0]     pcnt;       // cycles within the current bit
    logic [3:0]           bcnt;       // data bits / stop bits sent so far
    logic [DATA_BITS-1:0] shift;
    logic                 par_bit;
    logic                 bit_end;
    logic                 data_last;
    logic                 stop_last;
    logic                 phy;
    logic                 busy;

    assign bit_end   = (pcnt == CNT_W'(PRESCALER - 1));
    assign data_last = (bcnt == 4'(DATA_BITS - 1));
    assign stop_last = (bcnt == 4'(STOP_BITS - 1));

    always_ff @(posedge BusClk or negedge BusRstN) begin
        if (!BusRstN) state <= S_IDLE;
        else          state <= state_next;
    end

    // Next state; the FIFO pop is a transition event, so it lives here too.
    always_comb begin
        // NOTE: defaults first so every path assigns every output and no
        // latch is inferred.
        state_next = state;
        pop        = 1'b0;
        unique case (state)
            S_IDLE: begin
                if (!empty) begin
                    state_next = S_START;
                    pop        = 1'b1;
                end
            end
            S_START: begin
                if (bit_end) state_next = S_DATA;
            end
            S_DATA: begin
                if (bit_end && data_last) state_next = (PARITY != 0) ? S_PAR : S_STOP;
            end
            S_PAR: begin
                if (bit_end) state_next = S_STOP;
            end
            S_STOP: begin
                // Chain straight into the next start bit when data is waiting.
                if (bit_end && stop_last) begin
                    if (!empty) begin
                        state_next = S_START;
                        pop        = 1'b1;
                    end else begin
                        state_next = S_IDLE;
                    end
                end
            end
            default: state_next = S_IDLE;
        endcase
    end

    // Line level and busy follow the current state only.
    always_comb begin
        phy  = 1'b1;
        busy = 1'b1;
        unique case (state)
            S_IDLE:  busy = 1'b0;
            S_START: phy  = 1'b0;
            S_DATA:  phy  = shift[0];
            S_PAR:   phy  = par_bit;
            S_STOP:  phy  = 1'b1;
            default: busy = 1'b0;
        endcase
    end

    always_ff @(posedge BusClk or negedge BusRstN) begin
        if (!BusRstN) begin
            pcnt    <= '0;
            bcnt    <= '0;
            shift   <= '0;
            par_bit <= 1'b0;
        end else begin
            // Every state change happens on bit_end, so the wrap to zero also
            // lines the counter up with the next bit.
            if (state == S_IDLE || bit_end) pcnt <= '0;
            else                            pcnt <= pcnt + 1'b1;

            if (bit_end && state == S_DATA) bcnt <= data_last ? '0 : bcnt + 1'b1;
            if (bit_end && state == S_STOP) bcnt <= stop_last ? '0 : bcnt + 1'b1;

            if (pop) begin
                shift   <= head;
                par_bit <= (PARITY == 2) ? ^head : ~^head;
            end else if (bit_end && state == S_DATA) begin
                shift <= shift >> 1;
            end
        end
    end

    assign bus.BusFull  = full;
    assign bus.BusEmpty = empty;
    assign bus.BusLevel = level;
    assign bus.BusOvf   = ovf;
    assign bus.Busy     = busy;
    assign bus.PhyOut   = phy;
endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Three transmitters with different frame formats share one write stream:
//   dut 0: 8 data bits, no parity,   1 stop bit
//   dut 1: 7 data bits, even parity, 2 stop bits
//   dut 2: 8 data bits, odd parity,  1 stop bit
// A reference model (a queue of accepted words plus a frame bit list walked
// by cycle index) predicts every output each cycle.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;
    localparam int PRESC = 4;
    localparam int DEPTH = 4;
    localparam int NDUT  = 3;
    localparam int DB [NDUT] = '{8, 7, 8};
    localparam int PAR[NDUT] = '{0, 2, 1};
    localparam int SB [NDUT] = '{1, 2, 1};

    logic        clk   = 1'b0;
    logic        rst_n = 1'b0;
    logic        wr    = 1'b0;
    logic [31:0] data  = '0;

    always #5 clk = ~clk;

    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus0 ();
    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus1 ();
    uart_tx_fifo_if #(.FIFO_DEPTH(DEPTH)) bus2 ();

    assign bus0.BusWr = wr;  assign bus0.BusData = data;
    assign bus1.BusWr = wr;  assign bus1.BusData = data;
    assign bus2.BusWr = wr;  assign bus2.BusData = data;

    uart_tx_fifo #(.PRESCALER(PRESC), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u_dut0 (.BusClk(clk), .BusRstN(rst_n), .bus(bus0));
    uart_tx_fifo #(.PRESCALER(PRESC), .DATA_BITS(7), .PARITY(2), .STOP_BITS(2), .FIFO_DEPTH(DEPTH))
        u_dut1 (.BusClk(clk), .BusRstN(rst_n), .bus(bus1));
    uart_tx_fifo #(.PRESCALER(PRESC), .DATA_BITS(8), .PARITY(1), .STOP_BITS(1), .FIFO_DEPTH(DEPTH))
        u_dut2 (.BusClk(clk), .BusRstN(rst_n), .bus(bus2));

    logic [NDUT-1:0] phy_o, busy_o, full_o, empty_o, ovf_o;
    logic [2:0]      level_o [NDUT];

    assign phy_o   = {bus2.PhyOut,   bus1.PhyOut,   bus0.PhyOut};
    assign busy_o  = {bus2.Busy,     bus1.Busy,     bus0.Busy};
    assign full_o  = {bus2.BusFull,  bus1.BusFull,  bus0.BusFull};
    assign empty_o = {bus2.BusEmpty, bus1.BusEmpty, bus0.BusEmpty};
    assign ovf_o   = {bus2.BusOvf,   bus1.BusOvf,   bus0.BusOvf};
    assign level_o[0] = bus0.BusLevel;
    assign level_o[1] = bus1.BusLevel;
    assign level_o[2] = bus2.BusLevel;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s @%0t: got %0h, expected %0h", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------ reference model
    logic [8:0]  q [NDUT][$];     // accepted words, oldest first
    bit          tx_on [NDUT];    // a frame is on the line
    int          tx_cyc[NDUT];    // cycle index inside the frame
    int          tx_len[NDUT];    // frame length in cycles
    logic [15:0] tx_bits[NDUT];   // frame bits in line order
    bit          ovf_m [NDUT];

    function automatic int frame_nbits(input int k);
        return 1 + DB[k] + ((PAR[k] != 0) ? 1 : 0) + SB[k];
    endfunction

    // Start bit, data LSB first, optional parity, then ones for stop.
    function automatic logic [15:0] frame_of(input int k, input logic [8:0] d);
        logic [15:0] f;
        int ones;
        f    = '1;
        ones = 0;
        f[0] = 1'b0;
        for (int i = 0; i < DB[k]; i++) begin
            f[1 + i] = d[i];
            ones += int'(d[i]);
        end
        if (PAR[k] == 2) f[1 + DB[k]] = (ones % 2) == 1;   // even: total ones even
        if (PAR[k] == 1) f[1 + DB[k]] = (ones % 2) == 0;   // odd: total ones odd
        return f;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < NDUT; k++) begin
            q[k].delete();
            tx_on[k]  = 1'b0;
            tx_cyc[k] = 0;
            tx_len[k] = 0;
            tx_bits[k] = '1;
            ovf_m[k]  = 1'b0;
        end
    endtask

    // One clock edge, using the inputs as they were just before it.
    task automatic model_step();
        for (int k = 0; k < NDUT; k++) begin
            bit was_full, was_empty;
            was_full  = (q[k].size() == DEPTH);
            was_empty = (q[k].size() == 0);
            if (tx_on[k]) begin
                if (tx_cyc[k] == tx_len[k] - 1) tx_on[k] = 1'b0;
                else                            tx_cyc[k]++;
            end
            if (!tx_on[k] && !was_empty) begin
                tx_bits[k] = frame_of(k, q[k].pop_front());
                tx_len[k]  = frame_nbits(k) * PRESC;
                tx_cyc[k]  = 0;
                tx_on[k]   = 1'b1;
            end
            ovf_m[k] = wr && was_full;
            if (wr && !was_full) q[k].push_back(data[8:0]);
        end
    endtask

    task automatic check_all();
        for (int k = 0; k < NDUT; k++) begin
            logic exp_phy;
            exp_phy = tx_on[k] ? tx_bits[k][tx_cyc[k] / PRESC] : 1'b1;
            check($sformatf("phy[%0d]", k),   32'(phy_o[k]),   32'(exp_phy));
            check($sformatf("busy[%0d]", k),  32'(busy_o[k]),  32'(tx_on[k]));
            check($sformatf("level[%0d]", k), 32'(level_o[k]), 32'(q[k].size()));
            check($sformatf("full[%0d]", k),  32'(full_o[k]),  32'(q[k].size() == DEPTH));
            check($sformatf("empty[%0d]", k), 32'(empty_o[k]), 32'(q[k].size() == 0));
            check($sformatf("ovf[%0d]", k),   32'(ovf_o[k]),   32'(ovf_m[k]));
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        @(negedge clk);
        check_all();
    endtask

    task automatic write_then_idle(input logic [31:0] d, input int idle);
        wr   = 1'b1;
        data = d;
        tick();
        wr = 1'b0;
        repeat (idle) tick();
    endtask

    // --------------------------------------------------------------- stimulus
    initial begin
        int dens [4];
        dens = '{70, 20, 95, 40};

        model_reset();
        repeat (3) @(negedge clk);
        check_all();                       // reset state
        rst_n = 1'b1;

        // Single frames: 0x55 pattern, parity corner words, bit 7 ignored
        // on the 7-bit transmitter.
        write_then_idle(32'h55, 60);
        write_then_idle(32'h07, 60);
        write_then_idle(32'h00, 60);
        write_then_idle(32'hFF, 60);

        // Six writes on consecutive cycles: four queue behind the first,
        // the sixth overflows.
        for (int i = 0; i < 6; i++) begin
            wr   = 1'b1;
            data = $urandom;
            tick();
        end
        wr = 1'b0;
        repeat (300) tick();

        // Random traffic at several write densities.
        for (int s = 0; s < 4; s++) begin
            for (int c = 0; c < 500; c++) begin
                wr   = ($urandom_range(0, 99) < dens[s]);
                data = $urandom;
                tick();
            end
        end
        wr = 1'b0;
        repeat (300) tick();

        // Reset in the middle of a data bit; the line must recover at once.
        write_then_idle(32'hC3, 20);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        for (int k = 0; k < NDUT; k++) begin
            check($sformatf("rst_phy[%0d]", k),   32'(phy_o[k]),   32'd1);
            check($sformatf("rst_busy[%0d]", k),  32'(busy_o[k]),  32'd0);
            check($sformatf("rst_empty[%0d]", k), 32'(empty_o[k]), 32'd1);
            check($sformatf("rst_level[%0d]", k), 32'(level_o[k]), 32'd0);
        end
        @(negedge clk);
        @(negedge clk);
        check_all();
        rst_n = 1'b1;
        write_then_idle(32'hA5, 60);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
